// File: rtl/pong_video_timing.sv
// Horizontal/vertical video counter chain with registered, count-coherent
// blank, sync and terminal-count decodes for the Pong board.
module pong_video_timing #(
  parameter int unsigned H_TOTAL      = 455,
  parameter int unsigned H_BLANK_END  = 80,
  parameter int unsigned H_SYNC_START = 32,
  parameter int unsigned H_SYNC_END   = 64,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_BLANK_END  = 16,
  parameter int unsigned V_SYNC_START = 4,
  parameter int unsigned V_SYNC_END   = 8,
  localparam int unsigned CW          = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hreset,
  output logic          vreset,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync_n,
  output logic          vsync_n
);

  logic [CW-1:0] hcnt_nxt_c;
  logic [CW-1:0] vcnt_nxt_c;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          hreset_nxt_c;
  logic          vreset_nxt_c;
  logic          hblank_nxt_c;
  logic          vblank_nxt_c;
  logic          hsync_n_nxt_c;
  logic          vsync_n_nxt_c;

  // Next counts, then decodes taken from those next counts so every
  // registered output lines up with the count registered on the same edge.
  always_comb begin
    h_wrap_c   = (hcnt == CW'(H_TOTAL - 1));
    v_wrap_c   = (vcnt == CW'(V_TOTAL - 1));
    hcnt_nxt_c = h_wrap_c ? '0 : hcnt + CW'(1);
    vcnt_nxt_c = vcnt;
    if (h_wrap_c) begin
      vcnt_nxt_c = v_wrap_c ? '0 : vcnt + CW'(1);
    end

    hreset_nxt_c  = (hcnt_nxt_c == CW'(H_TOTAL - 1));
    vreset_nxt_c  = hreset_nxt_c && (vcnt_nxt_c == CW'(V_TOTAL - 1));
    hblank_nxt_c  = (hcnt_nxt_c < CW'(H_BLANK_END));
    vblank_nxt_c  = (vcnt_nxt_c < CW'(V_BLANK_END));
    hsync_n_nxt_c = !((hcnt_nxt_c >= CW'(H_SYNC_START)) &&
                      (hcnt_nxt_c <  CW'(H_SYNC_END)));
    vsync_n_nxt_c = !((vcnt_nxt_c >= CW'(V_SYNC_START)) &&
                      (vcnt_nxt_c <  CW'(V_SYNC_END)));
  end

  // State and decode registers; everything holds while ce is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hreset  <= 1'b0;
      vreset  <= 1'b0;
      hblank  <= 1'b1;
      vblank  <= 1'b1;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else if (ce) begin
      hcnt    <= hcnt_nxt_c;
      vcnt    <= vcnt_nxt_c;
      hreset  <= hreset_nxt_c;
      vreset  <= vreset_nxt_c;
      hblank  <= hblank_nxt_c;
      vblank  <= vblank_nxt_c;
      hsync_n <= hsync_n_nxt_c;
      vsync_n <= vsync_n_nxt_c;
    end
  end

endmodule

// File: tb/tb_pong_video_timing.sv
// Bench for pong_video_timing: a default-size instance plus a shrunken one
// (so full frames and wrap points are reachable quickly), both compared
// every cycle against a position-based model.
module tb_pong_video_timing;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;

  logic [8:0] hcnt, vcnt, s_hcnt, s_vcnt;
  logic       hreset, vreset, hblank, vblank, hsync_n, vsync_n;
  logic       s_hreset, s_vreset, s_hblank, s_vblank, s_hsync_n, s_vsync_n;

  int total = 0;
  int bad = 0;
  int p = 0;          // ce edges since reset release: the model's whole state
  bit checking = 1'b0;
  int last_p = -1;
  int vs_low = 0;
  int vb_high = 0;
  int last_vr = -1;

  always #5 clk = ~clk;

  pong_video_timing dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .hcnt(hcnt), .vcnt(vcnt), .hreset(hreset), .vreset(vreset),
    .hblank(hblank), .vblank(vblank), .hsync_n(hsync_n), .vsync_n(vsync_n)
  );

  pong_video_timing #(
    .H_TOTAL(40), .H_BLANK_END(12), .H_SYNC_START(4), .H_SYNC_END(8),
    .V_TOTAL(9), .V_BLANK_END(4), .V_SYNC_START(1), .V_SYNC_END(2)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .hcnt(s_hcnt), .vcnt(s_vcnt), .hreset(s_hreset), .vreset(s_vreset),
    .hblank(s_hblank), .vblank(s_vblank), .hsync_n(s_hsync_n), .vsync_n(s_vsync_n)
  );

  // Model: position in the raster is simply the number of ce edges seen.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= 0;
    else if (ce) p <= p + 1;
  end

  // Expected {hcnt, vcnt, hreset, vreset, hblank, vblank, hsync_n, vsync_n}.
  function automatic logic [23:0] model(input int pos, input int ht, input int hbe,
                                        input int hss, input int hse, input int vt,
                                        input int vbe, input int vss, input int vse);
    int h, v;
    logic hr;
    h  = pos % ht;
    v  = (pos / ht) % vt;
    hr = (h == ht - 1);
    return {9'(h), 9'(v), hr, hr && (v == vt - 1), (h < hbe), (v < vbe),
            !(h >= hss && h < hse), !(v >= vss && v < vse)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (p=%0d t=%0t)", name, act, exp, p, $time);
    end
  endtask

  // Per-cycle compare of both instances plus width/interval bookkeeping.
  always @(negedge clk) begin
    if (checking) begin
      check("main_vec", int'({hcnt, vcnt, hreset, vreset, hblank, vblank, hsync_n, vsync_n}),
            int'(model(p, 455, 80, 32, 64, 262, 16, 4, 8)));
      check("small_vec", int'({s_hcnt, s_vcnt, s_hreset, s_vreset, s_hblank, s_vblank,
                               s_hsync_n, s_vsync_n}),
            int'(model(p, 40, 12, 4, 8, 9, 4, 1, 2)));
      if (!reset_n) begin
        last_p  = -1;
        last_vr = -1;
      end else if (p != last_p) begin
        last_p = p;
        if (!vsync_n) vs_low++;
        if (vblank) vb_high++;
        if (s_vreset) begin
          if (last_vr >= 0) check("small_frame_len", p - last_vr, 360);
          last_vr = p;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    int lows;
    // Reset held, with ce both low and high.
    step(3);
    ce = 1'b1;
    step(2);
    check("rst_hcnt", int'(hcnt), 0);
    check("rst_vcnt", int'(vcnt), 0);
    check("rst_flags", int'({hreset, vreset, hblank, vblank, hsync_n, vsync_n}), 6'b001111);
    checking = 1'b1;
    reset_n  = 1'b1;

    step(1);
    check("first_edge_hcnt", int'(hcnt), 1);
    step(358);
    check("small_term_pos", int'({s_hcnt, s_vcnt}), int'({9'd39, 9'd8}));
    check("small_vreset", int'(s_vreset), 1);
    step(1);
    check("small_wrap", int'({s_hcnt, s_vcnt, s_vreset}), 0);
    step(94);
    check("h454_hcnt", int'(hcnt), 454);
    check("h454_hreset", int'(hreset), 1);
    check("h454_vcnt", int'(vcnt), 0);
    step(1);
    check("hwrap_state", int'({hcnt, vcnt, hreset}), int'({9'd0, 9'd1, 1'b0}));

    // One full line at vcnt=20.
    step(20 * 455 - p);
    lows = 0;
    for (int h = 0; h < 455; h++) begin
      check("line20_pos", int'({hcnt, vcnt}), int'({9'(h), 9'd20}));
      check("line20_hsync", int'(hsync_n), int'(!(h >= 32 && h < 64)));
      check("line20_hblank", int'(hblank), int'(h < 80));
      check("line20_vflags", int'({vblank, vsync_n}), 2'b01);
      if (!hsync_n) lows++;
      step(1);
    end
    check("hsync_width", lows, 32);
    check("vsync_low_periods", vs_low, 1820);
    check("vblank_high_periods", vb_high, 7280);

    // Sparse, randomly gapped ce.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      ce = ($urandom_range(0, 2) == 0);
    end
    ce = 1'b1;

    // Async reset mid-line between clock edges.
    step(100 * 455 + 300 - p);
    check("pre_reset_pos", int'({hcnt, vcnt}), int'({9'd300, 9'd100}));
    reset_n = 1'b0;
    #1;
    check("async_rst_counts", int'({hcnt, vcnt}), 0);
    check("async_rst_flags", int'({hreset, vreset, hblank, vblank, hsync_n, vsync_n}), 6'b001111);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    step(1);
    check("resume_first", int'({hcnt, vcnt}), int'({9'd1, 9'd0}));
    step(455);
    check("resume_line", int'({hcnt, vcnt}), int'({9'd1, 9'd1}));
    step(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_video_timing.md
Name: pong_video_timing

Overview:
- Synchronous horizontal/vertical counter chain for the Pong board; the source of the H/V count bits that the gate-level decode logic (4-input NAND terminal-count detectors and similar) consumes.
- Produces the 9-bit H and V counts, terminal-count pulses, and blank/sync strobes from a single pixel-rate clock enable.
- Sits between the clock generator and the net/score/ball video logic.
- All outputs are registered and coherent with each other.

Parameters:
- H_TOTAL, 455, pixels per line; hcnt range 0..H_TOTAL-1.
- H_BLANK_END, 80, hblank asserted while hcnt < H_BLANK_END.
- H_SYNC_START, 32, first hcnt with hsync_n low.
- H_SYNC_END, 64, first hcnt after hsync_n returns high.
- V_TOTAL, 262, lines per frame; vcnt range 0..V_TOTAL-1.
- V_BLANK_END, 16, vblank asserted while vcnt < V_BLANK_END.
- V_SYNC_START, 4, first vcnt with vsync_n low.
- V_SYNC_END, 8, first vcnt after vsync_n returns high.
- Legal values: H_SYNC_START < H_SYNC_END <= H_BLANK_END < H_TOTAL <= 512; the same ordering applies to V. Illegal values are out of scope; no runtime check.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- ce, input, 1, pixel clock enable; the state advances only on clk rising edges with ce=1.
- hcnt, output, 9, horizontal count.
- vcnt, output, 9, vertical count.
- hreset, output, 1, high while hcnt == H_TOTAL-1 (terminal count).
- vreset, output, 1, high while vcnt == V_TOTAL-1 and hcnt == H_TOTAL-1.
- hblank, output, 1, horizontal blank.
- vblank, output, 1, vertical blank.
- hsync_n, output, 1, active-low horizontal sync.
- vsync_n, output, 1, active-low vertical sync.

Behaviour:
- Reset: while reset_n=0, all state is cleared asynchronously, regardless of clk or ce.
  - hcnt=0, vcnt=0, hreset=0, vreset=0, hblank=1, vblank=1, hsync_n=1, vsync_n=1.
  - Release is synchronous: the first ce-qualified edge after release takes hcnt 0->1.
- ce=0: every register holds. Outputs are unchanged, and no pulses are stretched or generated.
- H counter, on each ce edge:
  - If hcnt == H_TOTAL-1, hcnt wraps to 0.
  - Otherwise hcnt increments by 1.
  - hcnt never takes a value >= H_TOTAL.
- V counter:
  - Advances only on the ce edge where hcnt wraps.
  - Wraps to 0 if vcnt == V_TOTAL-1, otherwise increments.
  - Simultaneous H and V wrap: both become 0 on the same edge.
- Decode outputs are registered from the next-state counts, so each output always describes the hcnt/vcnt value visible in the same cycle (zero relative latency, no glitches).
  - hblank = (hcnt < H_BLANK_END).
  - hsync_n = !(H_SYNC_START <= hcnt < H_SYNC_END).
  - vblank = (vcnt < V_BLANK_END).
  - vsync_n = !(V_SYNC_START <= vcnt < V_SYNC_END).
  - hreset = (hcnt == H_TOTAL-1).
  - vreset = hreset && (vcnt == V_TOTAL-1).
- Pulse widths, counted in ce periods:
  - hreset: 1 per line.
  - vreset: 1 per frame.
  - hsync_n low: H_SYNC_END-H_SYNC_START = 32.
  - vsync_n low: (V_SYNC_END-V_SYNC_START) lines = 4 x 455 ce periods.
- Reset mid-line or mid-frame: state returns immediately to the reset values above. There is no partial-line completion.
- Frame length: exactly H_TOTAL*V_TOTAL = 119210 ce periods between successive vreset pulses.

Test Plan:
- Reset hold, then release with ce=1 -> at release hcnt=0, vcnt=0, hblank=1, vblank=1, hsync_n=1, vsync_n=1; after 1 edge hcnt=1.
- 454 ce edges from reset -> hcnt=454 and hreset=1; next edge -> hcnt=0, vcnt=1, hreset=0.
- Line scan at vcnt=20 -> hsync_n low exactly for hcnt 32..63; hblank high for hcnt 0..79 and low at 80; vblank=0 and vsync_n=1 throughout.
- Full frame -> vsync_n low for vcnt 4..7 (1820 ce periods); vblank high for vcnt 0..15; vreset high for exactly 1 ce period at (454,261); next edge gives (0,0); 119210 periods between vreset pulses.
- ce toggled 1/3 duty with random gaps -> counts advance only on ce edges; outputs frozen during ce=0; decode stays coherent with the counts every cycle.
- Assert reset_n asynchronously mid-line at hcnt=300, vcnt=100, between clk edges -> outputs go to reset values before the next clk edge; counting resumes from 0,0 after release.
